// File: rtl/uart_pkg.sv
// Shared definitions for the UART output port: transmitter FSM states and 8N1 frame layout.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_e;

  localparam int unsigned DataBits  = 8;
  localparam int unsigned StartBits = 1;
  localparam int unsigned StopBits  = 1;
  localparam int unsigned FrameBits = StartBits + DataBits + StopBits;

endpackage

// File: rtl/fifo_sincrona.sv
// Single-clock FIFO with first-word fall-through read data; a push while full is accepted
// only when a pop happens in the same cycle.
module fifo_sincrona #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [Width-1:0] wdata_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the count gates every read.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_saida.sv
// Processor output port: bytes strobed in by load are queued and sent as 8N1 frames on tx.
module uart_saida
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] dadoIn,
  input  logic       load,
  output logic       tx,
  output logic       busy,
  output logic       full,
  output logic       overflow
);

  localparam int unsigned BaudW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
  localparam logic [2:0] BitLast = 3'(DataBits - 1);

  uart_state_e state_q, state_d;
  logic [BaudW-1:0] baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             overflow_q, overflow_d;

  logic       fifo_full, fifo_empty, pop;
  logic [7:0] fifo_rdata;
  logic       baud_end;

  assign pop      = (state_q == IDLE) && !fifo_empty;
  assign baud_end = (baud_q == BaudLast);

  fifo_sincrona #(
    .Width(8),
    .Depth(FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk),
    .rst_i  (rst),
    .push_i (load),
    .pop_i  (pop),
    .wdata_i(dadoIn),
    .rdata_o(fifo_rdata),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    overflow_d = overflow_q | (load & fifo_full & ~pop);
    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (pop) begin
          state_d = START;
          shift_d = fifo_rdata;
          tx_d    = 1'b0;
          baud_d  = '0;
          bit_d   = '0;
        end
      end
      START: begin
        if (baud_end) begin
          state_d = DATA;
          baud_d  = '0;
          tx_d    = shift_q[0];
          shift_d = {1'b0, shift_q[7:1]};
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == BitLast) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            tx_d    = shift_q[0];
            shift_d = {1'b0, shift_q[7:1]};
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      STOP: begin
        if (baud_end) begin
          state_d = IDLE;
          baud_d  = '0;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      overflow_q <= overflow_d;
    end
  end

  assign tx       = tx_q;
  assign busy     = (state_q != IDLE) || !fifo_empty;
  assign full     = fifo_full;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_saida.sv
// Directed bench for uart_saida with CLKS_PER_BIT=4, FIFO_DEPTH=4: a cycle table for reset and
// a single frame, then recorded-waveform checks for the multi-frame corner cases.
module tb_uart_saida;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] dadoIn = 8'h00;
  logic       load = 1'b0;
  logic       tx, busy, full, overflow;

  int n_cmp = 0;
  int n_err = 0;

  uart_saida #(
    .CLKS_PER_BIT(4),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .dadoIn  (dadoIn),
    .load    (load),
    .tx      (tx),
    .busy    (busy),
    .full    (full),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       load;
    logic [7:0] din;
    logic [3:0] exp;  // {tx, busy, full, overflow} after the edge
  } vec_t;

  vec_t vecs[$];

  // tx recorder: one sample per cycle, taken on the falling edge
  logic rec_en = 1'b0;
  logic txq[$];
  logic [7:0] exp_bytes[$];

  always @(negedge clk) if (rec_en) txq.push_back(tx);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic r, input logic l, input logic [7:0] d, input logic [3:0] e);
    vec_t v;
    v.rst = r; v.load = l; v.din = d; v.exp = e;
    vecs.push_back(v);
  endtask

  // Expected 41-cycle window of one frame: start, 8 data LSB first, stop plus one idle cycle.
  function automatic logic [40:0] frame_bits(input logic [7:0] b);
    logic [40:0] f;
    for (int j = 0; j < 41; j++) begin
      if (j < 4)       f[j] = 1'b0;
      else if (j < 36) f[j] = b[(j - 4) / 4];
      else             f[j] = 1'b1;
    end
    return f;
  endfunction

  // Recording must have started at the sample right after the first write's edge.
  task automatic check_stream(input string name);
    int need;
    int guard;
    logic [40:0] act;
    need  = 1 + 41 * exp_bytes.size();
    guard = 0;
    while (txq.size() < need && guard < 2000) begin
      tick();
      guard++;
    end
    chk({name, "_samples"}, 64'(txq.size() >= need), 64'(1'b1));
    if (txq.size() >= need) begin
      chk({name, "_lead_idle"}, 64'(txq[0]), 64'(1'b1));
      for (int i = 0; i < exp_bytes.size(); i++) begin
        for (int j = 0; j < 41; j++) act[j] = txq[1 + 41 * i + j];
        chk($sformatf("%s_frame%0d", name, i), 64'(act), 64'(frame_bits(exp_bytes[i])));
      end
    end
    rec_en = 1'b0;
    txq.delete();
    exp_bytes.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [9:0] a5_frame;
    logic       seen;

    // Reset with load held: nothing may be queued.
    add(1'b1, 1'b1, 8'hAA, 4'b1000);
    add(1'b1, 1'b1, 8'hAA, 4'b1000);
    add(1'b0, 1'b0, 8'h00, 4'b1000);
    add(1'b0, 1'b0, 8'h00, 4'b1000);
    // Single byte 0xA5: start, 1,0,1,0,0,1,0,1, stop
    a5_frame = 10'b1101001010;
    add(1'b0, 1'b1, 8'hA5, 4'b1100);
    for (int k = 1; k <= 40; k++) add(1'b0, 1'b0, 8'h00, {a5_frame[(k - 1) / 4], 3'b100});
    add(1'b0, 1'b0, 8'h00, 4'b1000);
    add(1'b0, 1'b0, 8'h00, 4'b1000);

    for (int i = 0; i < vecs.size(); i++) begin
      rst    = vecs[i].rst;
      load   = vecs[i].load;
      dadoIn = vecs[i].din;
      tick();
      chk($sformatf("vec%0d", i), 64'({tx, busy, full, overflow}), 64'(vecs[i].exp));
    end
    rst  = 1'b0;
    load = 1'b0;

    // Back-to-back 0x00, 0xFF
    load = 1'b1; dadoIn = 8'h00;
    tick();
    rec_en = 1'b1;
    dadoIn = 8'hFF;
    tick();
    load = 1'b0;
    exp_bytes.push_back(8'h00);
    exp_bytes.push_back(8'hFF);
    check_stream("b2b");
    chk("b2b_overflow", 64'(overflow), 64'(1'b0));

    // Overflow: 0x01..0x06, 0x06 is dropped
    for (int i = 0; i < 6; i++) begin
      load = 1'b1; dadoIn = 8'(i + 1);
      tick();
      if (i == 0) rec_en = 1'b1;
    end
    load = 1'b0;
    chk("ovf_full", 64'(full), 64'(1'b1));
    chk("ovf_flag", 64'(overflow), 64'(1'b1));
    for (int i = 1; i <= 5; i++) exp_bytes.push_back(8'(i));
    check_stream("ovf");
    tick();
    chk("ovf_busy_end", 64'(busy), 64'(1'b0));
    chk("ovf_sticky", 64'(overflow), 64'(1'b1));
    do_reset();
    chk("ovf_cleared", 64'(overflow), 64'(1'b0));

    // Fill to full, then write 0x77 exactly on the pop cycle after frame 1.
    for (int i = 0; i < 5; i++) begin
      load = 1'b1; dadoIn = 8'(8'h11 * (i + 1));
      tick();
      if (i == 0) rec_en = 1'b1;
    end
    load = 1'b0;
    chk("sim_full_before", 64'(full), 64'(1'b1));
    repeat (37) tick();
    load = 1'b1; dadoIn = 8'h77;
    tick();
    load = 1'b0;
    chk("sim_full_kept", 64'(full), 64'(1'b1));
    chk("sim_no_overflow", 64'(overflow), 64'(1'b0));
    for (int i = 0; i < 5; i++) exp_bytes.push_back(8'(8'h11 * (i + 1)));
    exp_bytes.push_back(8'h77);
    check_stream("sim");
    chk("sim_overflow_end", 64'(overflow), 64'(1'b0));

    // Reset during bit 3 of 0x3C with two more bytes queued.
    load = 1'b1; dadoIn = 8'h3C; tick();
    dadoIn = 8'h5A; tick();
    dadoIn = 8'h66; tick();
    load = 1'b0;
    repeat (8) tick();
    chk("mid_bit1", 64'(tx), 64'(1'b0));
    repeat (7) tick();
    chk("mid_bit3", 64'(tx), 64'(1'b1));
    chk("mid_busy_pre", 64'(busy), 64'(1'b1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_status", 64'({tx, busy, full, overflow}), 64'(4'b1000));
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (tx !== 1'b1 || busy !== 1'b0) seen = 1'b1;
    end
    chk("mid_quiet", 64'(seen), 64'(1'b0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_saida.md
# uart_saida

Output-port peripheral that consumes the processor's output register: every cycle `load` is high, the byte on `dadoIn` is queued in a small FIFO. The byte is then serialised as an 8N1 UART frame on `tx`. It sits directly downstream of the processor, with `dadoIn` fed by `pOUTPUT` and `load` fed by `LdOUTPUT`. Programs can therefore emit bytes back-to-back without stalling on the serial line.

## Interface
- `CLKS_PER_BIT`, default 434: clock cycles per serial bit (50 MHz / 115200); must be ≥ 2.
- `FIFO_DEPTH`, default 4: FIFO entries; must be a power of two ≥ 2.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `dadoIn`  in  8  byte to transmit.
- `load`  in  1  write strobe; one byte queued per high cycle.
- `tx`  out  1  serial line; idle high.
- `busy`  out  1  high while the FIFO is non-empty or a frame is in progress.
- `full`  out  1  FIFO holds `FIFO_DEPTH` entries.
- `overflow`  out  1  sticky; set when a write is dropped; cleared only by `rst`.

## Operation
- FIFO write: on `load`, if not `full` (or if full with a simultaneous pop), push `dadoIn`. Otherwise drop the byte and set `overflow`.
- FIFO pop: happens only in IDLE when the FIFO is non-empty. The popped byte is loaded into the shift register.
- FSM states and transitions:
  - IDLE -> START on pop.
  - START -> DATA after `CLKS_PER_BIT` cycles.
  - DATA -> STOP after 8 bits.
  - STOP -> IDLE after `CLKS_PER_BIT` cycles.
- Line level per state:
  - IDLE: `tx` = 1.
  - START: `tx` = 0.
  - DATA: bits sent LSB first, one per `CLKS_PER_BIT` cycles.
  - STOP: `tx` = 1.
- Counters:
  - Baud counter counts 0..`CLKS_PER_BIT`-1 and wraps to 0 on every bit boundary.
  - Bit index counts 0..7 with a 3-bit wrap.
- FIFO pointers are log2(`FIFO_DEPTH`) bits wide and wrap naturally. A count register of log2(`FIFO_DEPTH`)+1 bits distinguishes full from empty.
- `tx` is driven from a register, so it never glitches.
- Reset (including mid-frame): state = IDLE, FIFO emptied, counters zeroed, `overflow` cleared. The frame in progress is abandoned.

## Timing
- Reset values: `tx`=1, `busy`=0, `full`=0, `overflow`=0.
- Latency: with `load` high in cycle N and an idle, empty block:
  - The FIFO holds the byte after edge N.
  - The pop and the transition to START occur at edge N+1.
  - `tx` is 0 from edge N+1 onward.
- Frame length is exactly 10×`CLKS_PER_BIT` cycles.
- Back-to-back frames: when STOP ends with the FIFO non-empty, IDLE lasts exactly 1 cycle before the next START. That cycle has `tx`=1, so the stop bit lasts `CLKS_PER_BIT`+1 cycles.
- `busy` rises the cycle after the first accepted write. It falls the cycle after STOP completes with the FIFO empty.
- `full` and `overflow` update on the edge following the causing write.
- If `load` coincides with a pop while full, the write is accepted and `full` stays 1.
- If `load` and `rst` are high together, reset wins and nothing is queued.

## Structure
- Shared package `uart_pkg`:
  - FSM state enum: `IDLE`, `START`, `DATA`, `STOP`.
  - Frame constants: 8 data bits, 1 start bit, 1 stop bit.
- One sub-module, `fifo_sincrona`, parameterised by width and depth, with push/pop/full/empty. It is instantiated with width 8 and depth `FIFO_DEPTH`.
- The FSM, baud counter and shift register stay in `uart_saida`.

## Test plan
All scenarios use `CLKS_PER_BIT`=4 and `FIFO_DEPTH`=4.
- Reset: assert `rst` for 2 cycles -> `tx`=1, `busy`=0, `full`=0, `overflow`=0. Holding `load`=1 during reset queues nothing.
- Single byte: write 0xA5 -> `tx` is 0 from the second edge after the write. The sequence is 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles; `busy` is high for 41 cycles.
- Back-to-back: write 0x00 then 0xFF on consecutive cycles -> two frames, with the first stop bit lasting 5 cycles. The second frame's data bits are all 1, and `overflow`=0.
- Overflow: write 6 bytes 0x01..0x06 on consecutive cycles -> `full`=1 and `overflow`=1. 0x01..0x05 are transmitted in order and 0x06 is lost.
- Simultaneous write/pop while full: with a frame ending and the FIFO full, pulse `load` (0x77) on the pop cycle -> write accepted, `overflow` stays 0, and 0x77 is transmitted last.
- Reset mid-frame: assert `rst` during bit 3 of 0x3C with 2 bytes queued -> `tx`=1 from the next edge. No further frames are sent, and `busy`=0.
